// File: rtl/readout_pkg.sv
// Shared definitions for the readout token node: FSM encoding, header layout, CRC constants.
// Latency: n/a (constants only).
// Backpressure: n/a.
package readout_pkg;

    // Header layout, from the MSB down: node index, then frame sequence, then zero pad
    localparam int NODE_W = 5;
    localparam int SEQ_W  = 8;

    // Trailer CRC-8, MSB-first, init 0x00
    localparam int                CRC_W    = 8;
    localparam logic [CRC_W-1:0]  CRC_POLY = 8'h07;
    localparam logic [CRC_W-1:0]  CRC_INIT = 8'h00;

    // Frame FSM encoding (ST_TRL only reachable when the CRC trailer is built in)
    localparam int         ST_W    = 3;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_DAT  = 3'd2;
    localparam logic [2:0] ST_TRL  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_WREL = 3'd5;

endpackage

// File: rtl/readout_crc8.sv
// One-word CRC-8 update (poly CRC_POLY), word consumed MSB first.
// Latency: purely combinational.
// Backpressure: none; caller decides when to register the result.
module readout_crc8
    import readout_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [DATA_W-1:0] word,
    output logic [CRC_W-1:0]  crc_out
);

    // Bit-serial LFSR unrolled over the whole word; MSB-first bits equal MSB-first bytes
    always_comb begin
        logic [CRC_W-1:0] c;
        logic             fb;
        c  = crc_in;
        fb = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ word[i];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
        crc_out = c;
    end

endmodule

// File: rtl/readout_token_node.sv
// Token-ring readout node: on token grant sends header + captured sample (+ CRC-8 trailer
// when READOUT_CRC_EN is defined), then returns the token with a one-cycle TokenReady_o.
// Latency: first word valid one cycle after token capture; 2 words (3 with CRC) then one DONE cycle.
// Backpressure: RdValid_o/RdData_o hold until RdReady_i; one word per cycle with RdReady_i high.
module readout_token_node
    import readout_pkg::*;
#(
    parameter int               DATA_W  = 32,     // must be >= NODE_W + SEQ_W + 3 (16 or more)
    parameter logic [NODE_W-1:0] NODE_ID = 5'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              TokenValid_i,
    output logic              TokenReady_o,
    input  logic [DATA_W-1:0] Data_i,
    output logic [DATA_W-1:0] RdData_o,
    output logic              RdValid_o,
    input  logic              RdReady_i,
    output logic              Busy_o,
    output logic [7:0]        Seq_o
);

    logic [ST_W-1:0]   state_q;
    logic [ST_W-1:0]   state_d;
    logic [DATA_W-1:0] sample_q;
    logic [SEQ_W-1:0]  seq_q;
    logic [DATA_W-1:0] hdr_word;
    logic              word_acc;
    logic              frame_start;

    assign word_acc    = RdValid_o & RdReady_i;
    assign frame_start = (state_q == ST_IDLE) & TokenValid_i;

    // Header word: node index and sequence packed at the top, zero pad below
    always_comb begin
        hdr_word = '0;
        hdr_word[DATA_W-1 -: NODE_W]        = NODE_ID;
        hdr_word[DATA_W-NODE_W-1 -: SEQ_W]  = seq_q;
    end

`ifdef READOUT_CRC_EN
    logic [CRC_W-1:0]  crc_q;
    logic [CRC_W-1:0]  crc_next;
    logic [DATA_W-1:0] crc_word;
    logic [DATA_W-1:0] trl_word;

    assign crc_word = (state_q == ST_HDR) ? hdr_word : sample_q;

    readout_crc8 #(.DATA_W(DATA_W)) u_crc (
        .crc_in  (crc_q),
        .word    (crc_word),
        .crc_out (crc_next)
    );

    // Running CRC: restarted at token capture, folded in as each payload word is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= '0;
        end else if (frame_start) begin
            crc_q <= CRC_INIT;
        end else if (word_acc && (state_q == ST_HDR || state_q == ST_DAT)) begin
            crc_q <= crc_next;
        end
    end

    // Trailer word: CRC in the top byte, zero pad below
    always_comb begin
        trl_word = '0;
        trl_word[DATA_W-1 -: CRC_W] = crc_q;
    end
`endif

    // Next-state: words advance only on acceptance; a dropped token never aborts a frame
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (TokenValid_i) state_d = ST_HDR;
            ST_HDR:  if (word_acc)     state_d = ST_DAT;
`ifdef READOUT_CRC_EN
            ST_DAT:  if (word_acc)     state_d = ST_TRL;
            ST_TRL:  if (word_acc)     state_d = ST_DONE;
`else
            ST_DAT:  if (word_acc)     state_d = ST_DONE;
`endif
            ST_DONE: state_d = TokenValid_i ? ST_WREL : ST_IDLE;
            ST_WREL: if (!TokenValid_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, captured sample and frame sequence; seq bumps on every DONE exit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sample_q <= '0;
            seq_q    <= '0;
        end else begin
            state_q <= state_d;
            if (frame_start) begin
                sample_q <= Data_i;
            end
            if (state_q == ST_DONE) begin
                seq_q <= seq_q + 8'd1;
            end
        end
    end

    // Readout bus: word selected by state, zero when no word is offered
    always_comb begin
        RdValid_o = 1'b0;
        RdData_o  = '0;
        case (state_q)
            ST_HDR: begin
                RdValid_o = 1'b1;
                RdData_o  = hdr_word;
            end
            ST_DAT: begin
                RdValid_o = 1'b1;
                RdData_o  = sample_q;
            end
`ifdef READOUT_CRC_EN
            ST_TRL: begin
                RdValid_o = 1'b1;
                RdData_o  = trl_word;
            end
`endif
            default: begin
                RdValid_o = 1'b0;
                RdData_o  = '0;
            end
        endcase
    end

    assign TokenReady_o = (state_q == ST_DONE) & TokenValid_i;
    assign Busy_o       = (state_q != ST_IDLE);
    assign Seq_o        = seq_q;

endmodule

// File: tb/tb_readout_token_node.sv
// Randomized bench for readout_token_node against a frame-level reference model.
// Latency: n/a.
// Backpressure: RdReady_i driven fast, stalled or random per frame.
module tb_readout_token_node;

    localparam int MODE_FAST  = 0;
    localparam int MODE_STALL = 1;
    localparam int MODE_RAND  = 2;

    logic        clk;
    logic        rst;
    logic        TokenValid_i;
    logic        TokenReady_o;
    logic [31:0] Data_i;
    logic [31:0] RdData_o;
    logic        RdValid_o;
    logic        RdReady_i;
    logic        Busy_o;
    logic [7:0]  Seq_o;

    int total = 0;
    int bad   = 0;
    logic [7:0] seq_m;
    int frames;

    readout_token_node #(.DATA_W(32), .NODE_ID(5'd3)) dut (
        .clk          (clk),
        .rst          (rst),
        .TokenValid_i (TokenValid_i),
        .TokenReady_o (TokenReady_o),
        .Data_i       (Data_i),
        .RdData_o     (RdData_o),
        .RdValid_o    (RdValid_o),
        .RdReady_i    (RdReady_i),
        .Busy_o       (Busy_o),
        .Seq_o        (Seq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // CRC-8 poly 0x07 init 0, byte by byte from the MSB of header then data
    function automatic logic [7:0] ref_crc(input logic [31:0] w0, input logic [31:0] w1);
        logic [7:0]  c;
        logic [63:0] m;
        c = 8'h00;
        m = {w0, w1};
        for (int b = 0; b < 8; b++) begin
            c = c ^ m[63 - 8*b -: 8];
            for (int k = 0; k < 8; k++) begin
                c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
            end
        end
        return c;
    endfunction

    // One complete frame; hold = cycles the token stays high after return
    task automatic frame(input logic [31:0] d, input int mode, input bit drop, input int hold);
        logic [31:0] exp_q[$];
        logic [31:0] hdr;
        int          n;
        int          cyc;
        bit          r;
        hdr = {5'd3, seq_m, 19'd0};
        exp_q.push_back(hdr);
        exp_q.push_back(d);
`ifdef READOUT_CRC_EN
        exp_q.push_back({ref_crc(hdr, d), 24'd0});
`endif
        n = exp_q.size();
        TokenValid_i = 1'b1;
        Data_i       = d;
        RdReady_i    = 1'b0;
        @(negedge clk);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            if (drop) TokenValid_i = 1'b0;
            Data_i = $urandom;
            chk("rd_vld", 32'(RdValid_o), 32'd1);
            chk("rd_dat", RdData_o, exp_q[0]);
            chk("tok_rdy_mid", 32'(TokenReady_o), 32'd0);
            chk("busy_mid", 32'(Busy_o), 32'd1);
            case (mode)
                MODE_FAST:  r = 1'b1;
                MODE_STALL: r = (cyc >= 5);
                default:    r = ($urandom_range(0, 1) == 1);
            endcase
            RdReady_i = r;
            @(negedge clk);
            cyc++;
            if (r) void'(exp_q.pop_front());
        end
        chk("frame_timeout", 32'(exp_q.size()), 32'd0);
        if (mode == MODE_FAST) chk("b2b_cycles", 32'(cyc), 32'(n));
        RdReady_i = 1'b0;
        // DONE cycle: return pulse only if the token is still granted
        chk("done_vld", 32'(RdValid_o), 32'd0);
        chk("tok_rdy_done", 32'(TokenReady_o), drop ? 32'd0 : 32'd1);
        chk("done_seq", 32'(Seq_o), 32'(seq_m));
        seq_m = seq_m + 8'd1;
        frames++;
        if (hold == 0) TokenValid_i = 1'b0;
        @(negedge clk);
        chk("seq_after", 32'(Seq_o), 32'(seq_m));
        for (int h = 0; h < hold; h++) begin
            chk("wrel_busy", 32'(Busy_o), 32'd1);
            chk("wrel_vld", 32'(RdValid_o), 32'd0);
            chk("wrel_tok_rdy", 32'(TokenReady_o), 32'd0);
            if (h == hold - 1) TokenValid_i = 1'b0;
            @(negedge clk);
        end
        chk("idle_busy", 32'(Busy_o), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        TokenValid_i = 1'b0;
        Data_i       = '0;
        RdReady_i    = 1'b0;
        seq_m        = 8'd0;
        frames       = 0;
        repeat (3) @(negedge clk);
        chk("rst_vld", 32'(RdValid_o), 32'd0);
        chk("rst_dat", RdData_o, 32'd0);
        chk("rst_busy", 32'(Busy_o), 32'd0);
        chk("rst_tok_rdy", 32'(TokenReady_o), 32'd0);
        chk("rst_seq", 32'(Seq_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy0", 32'(Busy_o), 32'd0);

        // Known vector: NODE_ID 3, seq 0 -> 0x18000000 then the sample
        frame(32'hDEADBEEF, MODE_FAST, 1'b0, 1);
        chk("seq_one", 32'(Seq_o), 32'd1);
        // Five stalled cycles on the header
        frame($urandom, MODE_STALL, 1'b0, 1);
        // Token held ten cycles after return: must sit in WREL
        frame($urandom, MODE_FAST, 1'b0, 10);
        // Token dropped mid-frame: frame still completes, no return pulse
        frame($urandom, MODE_RAND, 1'b1, 0);

        while (frames < 256) begin
            bit drop;
            drop = ($urandom_range(0, 3) == 0);
            frame($urandom, $urandom_range(0, 2), drop, drop ? 0 : $urandom_range(0, 3));
        end
        chk("seq_wrap", 32'(Seq_o), 32'd0);
        frame($urandom, MODE_RAND, 1'b0, 1);

        // Reset in the middle of the data word
        TokenValid_i = 1'b1;
        Data_i       = $urandom;
        @(negedge clk);
        RdReady_i = 1'b1;
        @(negedge clk);
        RdReady_i = 1'b0;
        chk("pre_rst_vld", 32'(RdValid_o), 32'd1);
        chk("pre_rst_seq", 32'(Seq_o), 32'(seq_m));
        #2 rst = 1'b1;
        #1;
        chk("arst_vld", 32'(RdValid_o), 32'd0);
        chk("arst_dat", RdData_o, 32'd0);
        chk("arst_busy", 32'(Busy_o), 32'd0);
        chk("arst_tok_rdy", 32'(TokenReady_o), 32'd0);
        chk("arst_seq", 32'(Seq_o), 32'd0);
        TokenValid_i = 1'b0;
        @(negedge clk);
        rst   = 1'b0;
        seq_m = 8'd0;
        @(negedge clk);
        frame($urandom, MODE_RAND, 1'b0, 0);
        chk("post_rst_seq", 32'(Seq_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
